// File: rtl/issue_class_scheduler_pkg.sv
// Shared types and default sizes for the issue-class scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Exports the IssueClass enum, the default queue geometry and the path types
// sized for that geometry. The RTL modules take their parameter defaults from
// here.
package issue_class_scheduler_pkg;

  typedef enum logic [2:0] {
    ISSUE_CLASS_INT     = 3'd0,
    ISSUE_CLASS_COMPLEX = 3'd1,
    ISSUE_CLASS_LOAD    = 3'd2,
    ISSUE_CLASS_STORE   = 3'd3,
    ISSUE_CLASS_FP      = 3'd4
  } IssueClass;

  localparam int ISSUE_CLASS_NUM       = 5;
  localparam int ISSUE_QUEUE_ENTRY_NUM = 16;
  localparam int ISSUE_BLOCK_LAT       = 8;

  typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]                IssueQueueOneHotPath;
  typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM+1)-1:0]      ClassCountPath;
  typedef logic [$clog2(ISSUE_BLOCK_LAT+1)-1:0]            BlockCounterPath;

endpackage

// File: rtl/issue_class_block_timer.sv
// Busy timer for one unpipelined unit plus lowest-index blocking grant.
// Latency: busy rises the cycle after load and lasts BLOCK_LAT cycles.
// Backpressure: no grant is given while busy.
//
// Ports: clk, rst (async, active low), candidates (waiting blocking entries
// of this class), load (a blocking entry of this class issued this cycle),
// busy (counter != 0), grant (one-hot lowest candidate, 0 while busy).
module issue_class_block_timer
  import issue_class_scheduler_pkg::*;
#(
  parameter int ENTRY_NUM = ISSUE_QUEUE_ENTRY_NUM,
  parameter int BLOCK_LAT = ISSUE_BLOCK_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENTRY_NUM-1:0] candidates,
  input  logic                 load,
  output logic                 busy,
  output logic [ENTRY_NUM-1:0] grant
);

  localparam int CW = $clog2(BLOCK_LAT + 1);

  logic [CW-1:0] count;

  // A load while still counting simply restarts the unit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(BLOCK_LAT);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

  // x & -x isolates the lowest set bit.
  always_comb begin
    grant = '0;
    if (!busy) begin
      grant = candidates & (~candidates + ENTRY_NUM'(1));
    end
  end

endmodule

// File: rtl/issue_class_scheduler.sv
// Issue-queue tracker: per-entry waiting/class state, per-class request vectors,
// self-timed busy tracking for unpipelined units, per-class waiting counts.
// Latency: dispatch->request 1 cycle, issue/flush->drop 1 cycle. Backpressure: stall holds issue.
//
// Ports: clk, rst (async, active low), stall, write/writePtr/writeClass/
// writeBlocking (dispatch ports), selectedVector (one-hot per select port),
// flushVector; outputs notIssued, issueReq (class-major), classBusy,
// classCount (class-major), oldReq.
// Optional macro RSD_ISSUE_SCHED_AGE_EN adds per-entry age counters driving oldReq.
module issue_class_scheduler
  import issue_class_scheduler_pkg::*;
#(
  parameter int ENTRY_NUM      = ISSUE_QUEUE_ENTRY_NUM,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 4,
  parameter int CLASS_NUM      = ISSUE_CLASS_NUM,
  parameter int BLOCK_LAT      = ISSUE_BLOCK_LAT,
  parameter int AGE_MAX        = 15
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          stall,
  input  logic [DISPATCH_WIDTH-1:0]                     write,
  input  logic [DISPATCH_WIDTH*$clog2(ENTRY_NUM)-1:0]   writePtr,
  input  logic [DISPATCH_WIDTH*$clog2(CLASS_NUM)-1:0]   writeClass,
  input  logic [DISPATCH_WIDTH-1:0]                     writeBlocking,
  input  logic [ISSUE_WIDTH*ENTRY_NUM-1:0]              selectedVector,
  input  logic [ENTRY_NUM-1:0]                          flushVector,
  output logic [ENTRY_NUM-1:0]                          notIssued,
  output logic [CLASS_NUM*ENTRY_NUM-1:0]                issueReq,
  output logic [CLASS_NUM-1:0]                          classBusy,
  output logic [CLASS_NUM*$clog2(ENTRY_NUM+1)-1:0]      classCount,
  output logic [ENTRY_NUM-1:0]                          oldReq
);

  localparam int PW   = $clog2(ENTRY_NUM);
  localparam int CLW  = $clog2(CLASS_NUM);
  localparam int CNTW = $clog2(ENTRY_NUM + 1);

  logic [ENTRY_NUM-1:0] not_issued;
  logic [CLW-1:0]       entry_class [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] entry_blocking;

  logic [ENTRY_NUM-1:0] issued, clear, disp, accept;
  logic [CLW-1:0]       disp_class [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] disp_blocking;

  function automatic logic [CNTW-1:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < ENTRY_NUM; i++) n = n + CNTW'(v[i]);
    return n;
  endfunction

  always_comb begin
    issued = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) issued = issued | selectedVector[p*ENTRY_NUM +: ENTRY_NUM];
    if (stall) issued = '0;
  end

  assign clear = issued | flushVector;

  always_comb begin
    disp          = '0;
    disp_blocking = '0;
    for (int e = 0; e < ENTRY_NUM; e++) disp_class[e] = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (write[i]) begin
        disp[writePtr[i*PW +: PW]]          = 1'b1;
        disp_class[writePtr[i*PW +: PW]]    = writeClass[i*CLW +: CLW];
        disp_blocking[writePtr[i*PW +: PW]] = writeBlocking[i];
      end
    end
  end

  // A dispatch colliding with a clear of the same entry is dropped.
  assign accept = disp & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      not_issued <= '0;
    end else begin
      not_issued <= (not_issued & ~clear) | accept;
    end
  end

  // Payload is meaningless until not_issued is set, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < ENTRY_NUM; e++) begin
      if (disp[e]) begin
        entry_class[e]    <= disp_class[e];
        entry_blocking[e] <= disp_blocking[e];
      end
    end
  end

  assign notIssued = not_issued;

  for (genvar c = 0; c < CLASS_NUM; c++) begin : g_class
    logic [ENTRY_NUM-1:0] member, blk_wait, grant, disp_member;
    logic [CNTW-1:0]      count_q, add, rem;
    logic                 busy;

    always_comb begin
      member      = '0;
      disp_member = '0;
      for (int e = 0; e < ENTRY_NUM; e++) begin
        member[e]      = not_issued[e] && (entry_class[e] == CLW'(c));
        disp_member[e] = accept[e] && (disp_class[e] == CLW'(c));
      end
    end

    assign blk_wait = member & entry_blocking;

    issue_class_block_timer #(
      .ENTRY_NUM (ENTRY_NUM),
      .BLOCK_LAT (BLOCK_LAT)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .candidates (blk_wait),
      .load       (|(blk_wait & issued)),
      .busy       (busy),
      .grant      (grant)
    );

    assign issueReq[c*ENTRY_NUM +: ENTRY_NUM] = (member & ~entry_blocking) | grant;
    assign classBusy[c] = busy;

    assign add = popcnt(disp_member);
    assign rem = popcnt(member & clear);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + add - rem;
      end
    end

    assign classCount[c*CNTW +: CNTW] = count_q;

    always @(posedge clk) begin
      if (rst) begin
        assert (int'(count_q) + int'(add) >= int'(rem) &&
                int'(count_q) + int'(add) - int'(rem) <= ENTRY_NUM)
          else $error("classCount out of range for class %0d", c);
      end
    end
  end

`ifdef RSD_ISSUE_SCHED_AGE_EN
  localparam int AW = $clog2(AGE_MAX + 1);

  logic [AW-1:0] age [ENTRY_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < ENTRY_NUM; e++) age[e] <= '0;
    end else begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        if (disp[e]) begin
          age[e] <= '0;
        end else if (not_issued[e] && !issued[e] && age[e] != AW'(AGE_MAX)) begin
          age[e] <= age[e] + AW'(1);
        end
      end
    end
  end

  always_comb begin
    oldReq = '0;
    for (int e = 0; e < ENTRY_NUM; e++) oldReq[e] = not_issued[e] && (age[e] == AW'(AGE_MAX));
  end
`else
  assign oldReq = '0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      assert (BLOCK_LAT >= 1 && AGE_MAX >= 1) else $error("bad latency/age parameters");
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (write[i]) begin
          assert (!not_issued[writePtr[i*PW +: PW]]) else $error("dispatch to waiting entry");
          for (int j = i + 1; j < DISPATCH_WIDTH; j++) begin
            assert (!(write[j] && writePtr[j*PW +: PW] == writePtr[i*PW +: PW]))
              else $error("duplicate writePtr");
          end
        end
      end
      for (int e = 0; e < ENTRY_NUM; e++) begin
        automatic int n = 0;
        for (int p = 0; p < ISSUE_WIDTH; p++) n += int'(selectedVector[p*ENTRY_NUM + e]);
        assert (n <= 1) else $error("entry %0d selected by several ports", e);
        assert (n == 0 || not_issued[e]) else $error("entry %0d selected while not waiting", e);
      end
    end
  end

endmodule
